vde_vsids: RTL and testbench

- Parametrised successor to the single-lane variable decision engine in the SAT core. Keeps per-variable VSIDS activity, assigned flags and saved phases.
- Accepts NUM_BUMP parallel activity bumps per cycle. Decay is implemented by growing the bump increment, with automatic rescale on overflow.
- Picks the highest-activity unassigned variable with a banked scan of SCAN_LANES variables per cycle.
- Sits between the conflict analyser (bump/decay) and the solver control FSM (request/decision).

---
 rtl/vde_vsids.sv | 200 ++++++++++++++++++++
 tb/tb_vde_vsids.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vde_vsids.sv
// VSIDS variable decision engine: per-variable activity, assigned flags and saved phases,
// parallel bump lanes, decay by growing increment with rescale, banked best-variable scan.
module vde_vsids #(
    parameter int   MAX_VARS      = 64,
    parameter int   ACT_W         = 32,
    parameter int   NUM_BUMP      = 8,
    parameter int   SCAN_LANES    = 4,
    parameter int   DECAY_SHIFT   = 4,
    parameter int   RESCALE_SHIFT = 16,
    parameter logic PHASE_INIT    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   request,
    output logic                   decision_valid,
    output logic [31:0]            decision_var,
    output logic                   decision_phase,
    output logic                   all_assigned,
    input  logic [31:0]            max_var,
    input  logic                   clear_all,
    input  logic                   assign_valid,
    input  logic [31:0]            assign_var,
    input  logic                   assign_value,
    input  logic                   clear_valid,
    input  logic [31:0]            clear_var,
    input  logic [NUM_BUMP-1:0]    bump_valid,
    input  logic [NUM_BUMP*32-1:0] bump_vars,
    input  logic                   decay,
    output logic                   busy
);
    localparam int VW = $clog2(MAX_VARS + 1);
    localparam int PW = $clog2(MAX_VARS + SCAN_LANES + 1);
    localparam int HW = $clog2(NUM_BUMP + 1);
    localparam logic [ACT_W-1:0] ONE = ACT_W'(1);
    localparam logic [ACT_W-1:0] SAT = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [ACT_W-1:0] r_act   [1:MAX_VARS];
    logic             r_asg   [1:MAX_VARS];
    logic             r_phase [1:MAX_VARS];
    logic [ACT_W-1:0] r_inc;
    logic             r_rescale;

    state_t           r_state, w_state_next;
    logic [PW-1:0]    r_ptr, w_ptr_next;
    logic             r_found, w_found_next;
    logic [VW-1:0]    r_best, w_best_next;
    logic [ACT_W-1:0] r_best_act, w_best_act_next;

    logic [ACT_W-1:0] w_inc_eff, w_inc_step, w_inc_next;
    logic [ACT_W:0]   w_inc_sum;
    logic [MAX_VARS:1] w_top, w_bumped;
    logic [PW-1:0]    w_maxv;
    logic             w_asg_ok, w_clr_ok, w_update;

    // Increment seen by this cycle's bumps/decay is the post-rescale value when a rescale is pending.
    always_comb begin
        w_inc_eff = r_inc;
        if (r_rescale) begin
            w_inc_eff = r_inc >> RESCALE_SHIFT;
            if (w_inc_eff == '0) w_inc_eff = ONE;
        end
        w_inc_step = w_inc_eff >> DECAY_SHIFT;
        if (w_inc_step == '0) w_inc_step = ONE;
        w_inc_sum  = {1'b0, w_inc_eff} + {1'b0, w_inc_step};
        w_inc_next = w_inc_eff;
        if (decay) w_inc_next = w_inc_sum[ACT_W] ? SAT : w_inc_sum[ACT_W-1:0];
    end

    genvar gi;
    generate
        for (gi = 1; gi <= MAX_VARS; gi++) begin : g_var
            logic [HW-1:0]       w_hits;
            logic [ACT_W-1:0]    w_base, w_next;
            logic [ACT_W+HW-1:0] w_prod;
            logic [ACT_W+HW:0]   w_sum;

            always_comb begin
                w_hits = '0;
                for (int k = 0; k < NUM_BUMP; k++) begin
                    if (bump_valid[k] && (bump_vars[32*k +: 32] == 32'(gi)))
                        w_hits = w_hits + HW'(1);
                end
                w_base = r_rescale ? (r_act[gi] >> RESCALE_SHIFT) : r_act[gi];
                w_prod = (ACT_W+HW)'(w_inc_eff) * (ACT_W+HW)'(w_hits);
                w_sum  = (ACT_W+HW+1)'(w_base) + (ACT_W+HW+1)'(w_prod);
                w_next = (w_sum > (ACT_W+HW+1)'(SAT)) ? SAT : w_sum[ACT_W-1:0];
            end

            assign w_top[gi]    = w_next[ACT_W-1];
            assign w_bumped[gi] = (w_hits != '0);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_act[gi]   <= '0;
                    r_asg[gi]   <= 1'b0;
                    r_phase[gi] <= PHASE_INIT;
                end else begin
                    r_act[gi] <= w_next;
                    if (assign_valid && (assign_var == 32'(gi))) begin
                        r_asg[gi]   <= 1'b1;
                        r_phase[gi] <= assign_value;
                    end else if (clear_all) begin
                        r_asg[gi] <= 1'b0;
                    end else if (clear_valid && (clear_var == 32'(gi))) begin
                        r_asg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inc     <= ONE;
            r_rescale <= 1'b0;
        end else begin
            r_inc     <= w_inc_next;
            r_rescale <= (|w_top) | w_inc_next[ACT_W-1];
        end
    end

    assign w_asg_ok = assign_valid && (assign_var != 32'd0) && (assign_var <= 32'(MAX_VARS));
    assign w_clr_ok = clear_valid && (clear_var != 32'd0) && (clear_var <= 32'(MAX_VARS));
    assign w_update = w_asg_ok | w_clr_ok | clear_all | (|w_bumped) | decay | r_rescale;
    assign w_maxv   = (max_var > 32'(MAX_VARS)) ? PW'(MAX_VARS) : max_var[PW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= PW'(1);
            r_found    <= 1'b0;
            r_best     <= '0;
            r_best_act <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_found    <= w_found_next;
            r_best     <= w_best_next;
            r_best_act <= w_best_act_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_found_next    = r_found;
        w_best_next     = r_best;
        w_best_act_next = r_best_act;
        case (r_state)
            IDLE: begin
                if (request) begin
                    w_ptr_next   = PW'(1);
                    w_found_next = 1'b0;
                    w_state_next = (w_maxv == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (!request) begin
                    w_state_next = IDLE;
                end else if (w_update) begin
                    w_ptr_next   = PW'(1);
                    w_found_next = 1'b0;
                end else begin
                    // Lanes visited in ascending index order so ties keep the lower index.
                    for (int l = 0; l < SCAN_LANES; l++) begin
                        logic [PW-1:0] idx;
                        logic [VW-1:0] vi;
                        idx = r_ptr + PW'(l);
                        vi  = idx[VW-1:0];
                        if (idx <= w_maxv) begin
                            if (!r_asg[vi] && (!w_found_next || (r_act[vi] > w_best_act_next))) begin
                                w_found_next    = 1'b1;
                                w_best_next     = vi;
                                w_best_act_next = r_act[vi];
                            end
                        end
                    end
                    if (({1'b0, r_ptr} + (PW+1)'(SCAN_LANES)) > {1'b0, w_maxv})
                        w_state_next = DONE;
                    else
                        w_ptr_next = r_ptr + PW'(SCAN_LANES);
                end
            end
            DONE: begin
                if (!request) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        decision_valid = (r_state == DONE) && r_found;
        all_assigned   = (r_state == DONE) && !r_found;
        decision_var   = decision_valid ? 32'(r_best) : 32'd0;
        decision_phase = decision_valid ? r_phase[(r_best == '0) ? VW'(1) : r_best] : 1'b0;
        busy           = (r_state != IDLE);
    end
endmodule

// File: tb/tb_vde_vsids.sv
// Directed bench for vde_vsids: decisions, phases, multi-lane bumps, rescale, all-assigned, restarts.
module tb_vde_vsids;
    logic          clk = 1'b0;
    logic          reset, request, clear_all, assign_valid, assign_value, clear_valid, decay;
    logic [31:0]   max_var, assign_var, clear_var;
    logic [7:0]    bump_valid;
    logic [255:0]  bump_vars;
    logic          decision_valid, decision_phase, all_assigned, busy;
    logic [31:0]   decision_var;

    int n_checks = 0;
    int n_pass   = 0;

    vde_vsids dut (
        .clk(clk), .reset(reset), .request(request),
        .decision_valid(decision_valid), .decision_var(decision_var),
        .decision_phase(decision_phase), .all_assigned(all_assigned),
        .max_var(max_var), .clear_all(clear_all),
        .assign_valid(assign_valid), .assign_var(assign_var), .assign_value(assign_value),
        .clear_valid(clear_valid), .clear_var(clear_var),
        .bump_valid(bump_valid), .bump_vars(bump_vars), .decay(decay), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic bump_one(input int lane, input logic [31:0] v);
        bump_valid[lane]        = 1'b1;
        bump_vars[32*lane +: 32] = v;
    endtask

    task automatic clr_bumps();
        bump_valid = '0;
        bump_vars  = '0;
    endtask

    task automatic wait_out(inout int n);
        while (!(decision_valid || all_assigned) && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic req_and_wait(output int n);
        request = 1'b1;
        n = 0;
        wait_out(n);
    endtask

    task automatic drop_req();
        request = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] inc_m, step;
        reset = 1'b0; request = 1'b0; clear_all = 1'b0; assign_valid = 1'b0; assign_value = 1'b0;
        clear_valid = 1'b0; decay = 1'b0; max_var = 32'd10; assign_var = '0; clear_var = '0;
        clr_bumps();
        do_reset();

        chk("rst_valid", decision_valid, 0);
        chk("rst_all", all_assigned, 0);
        chk("rst_var", decision_var, 0);
        chk("rst_busy", busy, 0);

        // Reset mid-scan aborts silently
        request = 1'b1;
        tick(); tick();
        chk("scan_busy", busy, 1);
        reset = 1'b1; tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", decision_valid, 0);
        request = 1'b0; reset = 1'b0; tick();

        // All-zero activities: lowest index wins
        req_and_wait(n);
        chk("t1_lat", n, 4);
        chk("t1_valid", decision_valid, 1);
        chk("t1_var", decision_var, 1);
        chk("t1_phase", decision_phase, 0);
        drop_req();
        chk("t1_cleared", decision_valid, 0);

        // Phase saved across clear
        assign_valid = 1'b1; assign_var = 32'd1; assign_value = 1'b1; tick();
        assign_valid = 1'b0; clear_valid = 1'b1; clear_var = 32'd1; tick();
        clear_valid = 1'b0; bump_one(0, 32'd1); tick();
        clr_bumps();
        req_and_wait(n);
        chk("t2_var", decision_var, 1);
        chk("t2_phase", decision_phase, 1);
        drop_req();

        // Duplicate lanes accumulate
        bump_one(0, 32'd5); bump_one(1, 32'd5); bump_one(2, 32'd5); bump_one(3, 32'd7);
        bump_one(4, 32'd0); bump_one(5, 32'd65);
        tick();
        clr_bumps();
        chk("t3_act5", dut.r_act[5], 3);
        chk("t3_act7", dut.r_act[7], 1);
        req_and_wait(n);
        chk("t3_var", decision_var, 5);
        drop_req();

        // Rescale after a bump overflows bit ACT_W-1
        do_reset();
        bump_one(0, 32'd2); tick(); clr_bumps();
        inc_m = 32'd1;
        forever begin
            step = inc_m >> 4;
            if (step == 0) step = 1;
            if (inc_m + step >= 32'h8000_0000) break;
            decay = 1'b1; tick();
            inc_m = inc_m + step;
        end
        decay = 1'b0;
        chk("t4_inc_pre", dut.r_inc, inc_m);
        bump_one(0, 32'd3); bump_one(1, 32'd3); tick(); clr_bumps();
        chk("t4_act3_pre", dut.r_act[3], 2 * inc_m);
        tick();
        chk("t4_act3", dut.r_act[3], (2 * inc_m) >> 16);
        chk("t4_act2", dut.r_act[2], 0);
        chk("t4_inc", dut.r_inc, inc_m >> 16);
        req_and_wait(n);
        chk("t4_var", decision_var, 3);
        drop_req();

        // All assigned; assign beats clear on the same variable
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            assign_valid = 1'b1; assign_var = 32'(v); assign_value = v[0];
            if (v == 10) begin clear_valid = 1'b1; clear_var = 32'd10; end
            tick();
        end
        assign_valid = 1'b0; clear_valid = 1'b0;
        req_and_wait(n);
        chk("t5_lat", n, 4);
        chk("t5_all", all_assigned, 1);
        tick(); tick(); tick();
        chk("t5_all_held", all_assigned, 1);
        chk("t5_valid", decision_valid, 0);
        drop_req();
        chk("t5_all_clr", all_assigned, 0);
        chk("t5_busy", busy, 0);
        clear_all = 1'b1; tick(); clear_all = 1'b0;
        req_and_wait(n);
        chk("t5_clrall_var", decision_var, 1);
        drop_req();

        // Restart on bump during second scan cycle
        do_reset();
        request = 1'b1; n = 0;
        tick(); n++;
        tick(); n++;
        bump_one(0, 32'd9);
        tick(); n++;
        clr_bumps();
        wait_out(n);
        chk("t6_lat", n, 6);
        chk("t6_var", decision_var, 9);
        drop_req();

        // max_var clamp to MAX_VARS and max_var == 0
        do_reset();
        max_var = 32'd100;
        bump_one(0, 32'd64); tick(); clr_bumps();
        req_and_wait(n);
        chk("clamp_lat", n, 17);
        chk("clamp_var", decision_var, 64);
        drop_req();
        max_var = 32'd0;
        req_and_wait(n);
        chk("zero_lat", n, 1);
        chk("zero_all", all_assigned, 1);
        drop_req();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
